decode_stage_hs: RTL and testbench

//  Handshaked, parametrised ID stage between fetch and execute. Holds IF/ID and ID/EX registers.

---
 rtl/decode_stage_hs.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hs.sv
// decode_stage_hs
//  Handshaked instruction-decode stage sitting between fetch and execute.
//  Holds the IF/ID register (instruction, PC+4, valid) and the ID/EX register
//  (decoded fields, operands, control bits). Contains the architectural
//  register file with write-through bypass from the write-back port, a
//  load-use hazard detector, flush squash, jump-target calculation,
//  single-step gating and a sticky halt.
//
//  Ports
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_valid_in / o_ready_in   fetch-side handshake, i_instruction, i_pc_next
//   o_valid / i_ready         execute-side handshake
//   i_flush                   squash IF/ID, accept nothing this cycle
//   i_execution_mode, i_step  0 = run continuously, 1 = advance on i_step only
//   i_wb_en/i_wb_sel/i_wb_data register-file write port
//   i_dbg_sel / o_dbg_data    combinational debug read (no bypass)
//   o_rs..o_reg_write         ID/EX contents
//   o_halted                  sticky halt, cleared only by reset
module decode_stage_hs #(
  parameter int NB_DATA     = 32,
  parameter int NB_REGISTER = 5,
  parameter int N_REGS      = 32,
  parameter int NB_OPCODE   = 6
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid_in,
  output logic                   o_ready_in,
  input  logic [31:0]            i_instruction,
  input  logic [NB_DATA-1:0]     i_pc_next,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic                   i_flush,
  input  logic                   i_execution_mode,
  input  logic                   i_step,
  input  logic                   i_wb_en,
  input  logic [NB_REGISTER-1:0] i_wb_sel,
  input  logic [NB_DATA-1:0]     i_wb_data,
  input  logic [NB_REGISTER-1:0] i_dbg_sel,
  output logic [NB_DATA-1:0]     o_dbg_data,
  output logic [NB_REGISTER-1:0] o_rs,
  output logic [NB_REGISTER-1:0] o_rt,
  output logic [NB_REGISTER-1:0] o_rd,
  output logic [NB_REGISTER-1:0] o_sa,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic [NB_DATA-1:0]     o_pc_next,
  output logic [NB_DATA-1:0]     o_data_rs,
  output logic [NB_DATA-1:0]     o_data_rt,
  output logic [NB_DATA-1:0]     o_extended,
  output logic [NB_DATA-1:0]     o_pc_jump,
  output logic [1:0]             o_alu_op,
  output logic [1:0]             o_jump,
  output logic                   o_alu_src,
  output logic                   o_reg_dst,
  output logic                   o_branch,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_mem_to_reg,
  output logic                   o_reg_write,
  output logic                   o_halted
);

  localparam int N_SLOTS = 2 ** NB_REGISTER;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  logic [31:0]        ifid_instr_reg;
  logic [NB_DATA-1:0] ifid_pc_reg;
  logic               ifid_valid_reg;

  logic [5:0]             ifid_opcode;
  logic [5:0]             ifid_funct;
  logic [NB_REGISTER-1:0] ifid_rs;
  logic [NB_REGISTER-1:0] ifid_rt;
  logic [NB_REGISTER-1:0] ifid_rd;
  logic [NB_REGISTER-1:0] ifid_sa;
  logic [15:0]            ifid_imm;

  assign ifid_opcode = ifid_instr_reg[31:26];
  assign ifid_rs     = NB_REGISTER'(ifid_instr_reg[25:21]);
  assign ifid_rt     = NB_REGISTER'(ifid_instr_reg[20:16]);
  assign ifid_rd     = NB_REGISTER'(ifid_instr_reg[15:11]);
  assign ifid_sa     = NB_REGISTER'(ifid_instr_reg[10:6]);
  assign ifid_funct  = ifid_instr_reg[5:0];
  assign ifid_imm    = ifid_instr_reg[15:0];

  // ---------------------------------------------------------------------------
  // Handshake / hazard control
  // ---------------------------------------------------------------------------
  logic adv;
  logic exld;
  logic stall;
  logic issue;

  assign adv  = (~i_execution_mode | i_step) & ~o_halted;
  assign exld = adv & (~o_valid | i_ready);

  // A load in ID/EX whose destination is a source of the instruction waiting
  // in IF/ID: hold IF/ID one cycle and send a bubble so the load data can be
  // forwarded/written back before the dependent instruction reads it.
  assign stall = ifid_valid_reg & o_mem_read & o_valid & (o_rt != '0) &
                 ((o_rt == ifid_rs) | (o_rt == ifid_rt));

  assign o_ready_in = exld & ~stall & ~i_flush & ~i_reset;

  // A real instruction moves into ID/EX only when IF/ID holds one and it is
  // neither stalled nor squashed; every other ID/EX load is a bubble.
  assign issue = ifid_valid_reg & ~stall & ~i_flush;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ifid_instr_reg <= '0;
      ifid_pc_reg    <= '0;
      ifid_valid_reg <= 1'b0;
    end else if (i_flush) begin
      ifid_valid_reg <= 1'b0;
    end else if (o_ready_in) begin
      ifid_instr_reg <= i_instruction;
      ifid_pc_reg    <= i_pc_next;
      ifid_valid_reg <= i_valid_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. Sized to the full index space; slots at or above N_REGS are
  // never written and never read, so they stay at zero.
  // ---------------------------------------------------------------------------
  logic [NB_DATA-1:0] reg_file [N_SLOTS];
  logic               wb_write;

  function automatic logic idx_in_range(input logic [NB_REGISTER-1:0] idx);
    return (32'(idx) < 32'(N_REGS));
  endfunction

  // Operand read with write-through: a write landing on the same edge that
  // the operand is captured is seen by the decoding instruction.
  function automatic logic [NB_DATA-1:0] read_operand(
    input logic [NB_REGISTER-1:0] idx,
    input logic [NB_DATA-1:0]     stored,
    input logic                   wb_en,
    input logic [NB_REGISTER-1:0] wb_sel,
    input logic [NB_DATA-1:0]     wb_data
  );
    if ((idx == '0) || !idx_in_range(idx)) begin
      return '0;
    end else if (wb_en && (wb_sel == idx)) begin
      return wb_data;
    end else begin
      return stored;
    end
  endfunction

  assign wb_write = i_wb_en & (i_wb_sel != '0) & idx_in_range(i_wb_sel);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        reg_file[i] <= '0;
      end
    end else if (wb_write) begin
      reg_file[i_wb_sel] <= i_wb_data;
    end
  end

  assign o_dbg_data = idx_in_range(i_dbg_sel) ? reg_file[i_dbg_sel] : '0;

  // ---------------------------------------------------------------------------
  // Decode (combinational next values for ID/EX)
  // ---------------------------------------------------------------------------
  logic [NB_DATA-1:0] data_rs_next;
  logic [NB_DATA-1:0] data_rt_next;
  logic [NB_DATA-1:0] extended_next;
  logic [NB_DATA-1:0] pc_jump_next;
  logic [1:0]         alu_op_next;
  logic [1:0]         jump_next;
  logic               alu_src_next;
  logic               reg_dst_next;
  logic               branch_next;
  logic               mem_read_next;
  logic               mem_write_next;
  logic               mem_to_reg_next;
  logic               reg_write_next;
  logic               halt_next;

  assign data_rs_next  = read_operand(ifid_rs, reg_file[ifid_rs], i_wb_en, i_wb_sel, i_wb_data);
  assign data_rt_next  = read_operand(ifid_rt, reg_file[ifid_rt], i_wb_en, i_wb_sel, i_wb_data);
  assign extended_next = {{(NB_DATA-16){ifid_imm[15]}}, ifid_imm};
  assign halt_next     = (ifid_opcode == OP_HALT);

  always_comb begin
    alu_op_next     = 2'b00;
    jump_next       = 2'b00;
    alu_src_next    = 1'b0;
    reg_dst_next    = 1'b0;
    branch_next     = 1'b0;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    mem_to_reg_next = 1'b0;
    reg_write_next  = 1'b0;
    case (ifid_opcode)
      OP_RTYPE: begin
        alu_op_next  = 2'b10;
        reg_dst_next = 1'b1;
        if (ifid_funct == FN_JR) begin
          jump_next = 2'b10;
        end else begin
          reg_write_next = 1'b1;
        end
      end
      OP_LW: begin
        alu_src_next    = 1'b1;
        mem_read_next   = 1'b1;
        mem_to_reg_next = 1'b1;
        reg_write_next  = 1'b1;
      end
      OP_SW: begin
        alu_src_next   = 1'b1;
        mem_write_next = 1'b1;
      end
      OP_BEQ: begin
        alu_op_next = 2'b01;
        branch_next = 1'b1;
      end
      OP_ADDI: begin
        alu_src_next   = 1'b1;
        reg_write_next = 1'b1;
      end
      OP_J: begin
        jump_next = 2'b01;
      end
      OP_JAL: begin
        jump_next      = 2'b01;
        reg_write_next = 1'b1;
      end
      default: begin
        // HALT and unknown opcodes carry no control.
      end
    endcase
  end

  always_comb begin
    pc_jump_next = '0;
    case (jump_next)
      2'b01:   pc_jump_next = {ifid_pc_reg[NB_DATA-1:28], ifid_instr_reg[25:0], 2'b00};
      2'b10:   pc_jump_next = data_rs_next;
      default: pc_jump_next = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_sa         <= '0;
      o_opcode     <= '0;
      o_pc_next    <= '0;
      o_data_rs    <= '0;
      o_data_rt    <= '0;
      o_extended   <= '0;
      o_pc_jump    <= '0;
      o_alu_op     <= '0;
      o_jump       <= '0;
      o_alu_src    <= 1'b0;
      o_reg_dst    <= 1'b0;
      o_branch     <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_halted     <= 1'b0;
    end else if (exld) begin
      if (issue) begin
        o_valid      <= 1'b1;
        o_rs         <= ifid_rs;
        o_rt         <= ifid_rt;
        o_rd         <= ifid_rd;
        o_sa         <= ifid_sa;
        o_opcode     <= NB_OPCODE'(ifid_opcode);
        o_pc_next    <= ifid_pc_reg;
        o_data_rs    <= data_rs_next;
        o_data_rt    <= data_rt_next;
        o_extended   <= extended_next;
        o_pc_jump    <= pc_jump_next;
        o_alu_op     <= alu_op_next;
        o_jump       <= jump_next;
        o_alu_src    <= alu_src_next;
        o_reg_dst    <= reg_dst_next;
        o_branch     <= branch_next;
        o_mem_read   <= mem_read_next;
        o_mem_write  <= mem_write_next;
        o_mem_to_reg <= mem_to_reg_next;
        o_reg_write  <= reg_write_next;
        if (halt_next) begin
          o_halted <= 1'b1;
        end
      end else begin
        // Bubble: nothing of a stalled or squashed instruction leaks out.
        o_valid      <= 1'b0;
        o_rs         <= '0;
        o_rt         <= '0;
        o_rd         <= '0;
        o_sa         <= '0;
        o_opcode     <= '0;
        o_pc_next    <= '0;
        o_data_rs    <= '0;
        o_data_rt    <= '0;
        o_extended   <= '0;
        o_pc_jump    <= '0;
        o_alu_op     <= '0;
        o_jump       <= '0;
        o_alu_src    <= 1'b0;
        o_reg_dst    <= 1'b0;
        o_branch     <= 1'b0;
        o_mem_read   <= 1'b0;
        o_mem_write  <= 1'b0;
        o_mem_to_reg <= 1'b0;
        o_reg_write  <= 1'b0;
      end
    end else if (o_halted && o_valid && i_ready) begin
      // Once halted the stage is frozen, but the HALT itself is still handed
      // to execute exactly once; the fields stay put for inspection.
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Testbench for decode_stage_hs: table-driven stream checked through a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_decode_stage_hs;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid_in;
  logic        o_ready_in;
  logic [31:0] i_instruction;
  logic [31:0] i_pc_next;
  logic        o_valid;
  logic        i_ready;
  logic        i_flush;
  logic        i_execution_mode;
  logic        i_step;
  logic        i_wb_en;
  logic [4:0]  i_wb_sel;
  logic [31:0] i_wb_data;
  logic [4:0]  i_dbg_sel;
  logic [31:0] o_dbg_data;
  logic [4:0]  o_rs, o_rt, o_rd, o_sa;
  logic [5:0]  o_opcode;
  logic [31:0] o_pc_next, o_data_rs, o_data_rt, o_extended, o_pc_jump;
  logic [1:0]  o_alu_op, o_jump;
  logic        o_alu_src, o_reg_dst, o_branch, o_mem_read, o_mem_write;
  logic        o_mem_to_reg, o_reg_write, o_halted;

  decode_stage_hs dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_valid_in(i_valid_in), .o_ready_in(o_ready_in),
    .i_instruction(i_instruction), .i_pc_next(i_pc_next),
    .o_valid(o_valid), .i_ready(i_ready), .i_flush(i_flush),
    .i_execution_mode(i_execution_mode), .i_step(i_step),
    .i_wb_en(i_wb_en), .i_wb_sel(i_wb_sel), .i_wb_data(i_wb_data),
    .i_dbg_sel(i_dbg_sel), .o_dbg_data(o_dbg_data),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_sa(o_sa),
    .o_opcode(o_opcode), .o_pc_next(o_pc_next),
    .o_data_rs(o_data_rs), .o_data_rt(o_data_rt),
    .o_extended(o_extended), .o_pc_jump(o_pc_jump),
    .o_alu_op(o_alu_op), .o_jump(o_jump),
    .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst), .o_branch(o_branch),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_halted(o_halted)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic drain();
    i_valid_in = 1'b0;
    i_ready    = 1'b1;
    i_flush    = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic [10:0] ctrl_now();
    return {o_alu_op, o_jump, o_alu_src, o_reg_dst, o_branch,
            o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write};
  endfunction

  // ctrl = {alu_op, jump, alu_src, reg_dst, branch, mem_read, mem_write, mem_to_reg, reg_write}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [25:0] fields;   // {opcode, rs, rt, rd, sa}
    logic [10:0] ctrl;
    logic [31:0] drs;
    logic [31:0] drt;
    logic [31:0] ext;
    logic [31:0] jmp;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];
  int   sb_q [$];

  initial begin
    int k;
    int cyc;
    int idx;
    int ks;
    logic        prev_step;
    logic        snap_v;
    logic [31:0] snap_pc;
    logic [31:0] step_instr [3];
    logic [31:0] step_pc [3];

    // Registers are preloaded with r[i] = i * 0x11.
    tbl[0] = '{32'h8CA40008, 32'h00000104, {6'h23, 5'd5,  5'd4,  5'd0,  5'd0},  11'b00_00_1001011, 32'h55,  32'h44,  32'h00000008, 32'h0};
    tbl[1] = '{32'h00811820, 32'h00000108, {6'h00, 5'd4,  5'd1,  5'd3,  5'd0},  11'b10_00_0100001, 32'h44,  32'h11,  32'h00001820, 32'h0};
    tbl[2] = '{32'hACE6FFFC, 32'h0000010C, {6'h2B, 5'd7,  5'd6,  5'd31, 5'd31}, 11'b00_00_1000100, 32'h77,  32'h66,  32'hFFFFFFFC, 32'h0};
    tbl[3] = '{32'h10220003, 32'h00000110, {6'h04, 5'd1,  5'd2,  5'd0,  5'd0},  11'b01_00_0010000, 32'h11,  32'h22,  32'h00000003, 32'h0};
    tbl[4] = '{32'h21287FFF, 32'h00000114, {6'h08, 5'd9,  5'd8,  5'd15, 5'd31}, 11'b00_00_1000001, 32'h99,  32'h88,  32'h00007FFF, 32'h0};
    tbl[5] = '{32'h08000010, 32'h40000008, {6'h02, 5'd0,  5'd0,  5'd0,  5'd0},  11'b00_01_0000000, 32'h0,   32'h0,   32'h00000010, 32'h40000040};
    tbl[6] = '{32'h0FFFFFFF, 32'h80000004, {6'h03, 5'd31, 5'd31, 5'd31, 5'd31}, 11'b00_01_0000001, 32'h20F, 32'h20F, 32'hFFFFFFFF, 32'h8FFFFFFC};
    tbl[7] = '{32'h01400008, 32'h0000011C, {6'h00, 5'd10, 5'd0,  5'd0,  5'd0},  11'b10_10_0100000, 32'hAA,  32'h0,   32'h00000008, 32'hAA};
    tbl[8] = '{32'h3C0B1234, 32'h00000120, {6'h0F, 5'd0,  5'd11, 5'd2,  5'd8},  11'b00_00_0000000, 32'h0,   32'hBB,  32'h00001234, 32'h0};

    // ---------------- reset ----------------
    i_reset = 1'b1; i_valid_in = 1'b0; i_instruction = '0; i_pc_next = '0;
    i_ready = 1'b1; i_flush = 1'b0; i_execution_mode = 1'b0; i_step = 1'b0;
    i_wb_en = 1'b0; i_wb_sel = '0; i_wb_data = '0; i_dbg_sel = 5'd1;
    @(negedge i_clock);
    repeat (3) tick();
    #1;
    check("reset_ready_in", o_ready_in, 1'b0);
    check("reset_valid", o_valid, 1'b0);
    check("reset_halted", o_halted, 1'b0);
    check("reset_outputs", {o_opcode, o_pc_next, o_data_rs, ctrl_now()}, '0);
    check("reset_regfile", o_dbg_data, 32'h0);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check("ready_after_reset", o_ready_in, 1'b1);

    // ---------------- preload register file ----------------
    for (int i = 1; i < 32; i++) begin
      i_wb_en = 1'b1; i_wb_sel = 5'(i); i_wb_data = 32'(i * 17);
      tick();
    end
    i_wb_sel = 5'd0; i_wb_data = 32'hBEEF;
    tick();
    i_wb_en = 1'b0;
    i_dbg_sel = 5'd0;  #1; check("dbg_r0_write_ignored", o_dbg_data, 32'h0);
    i_dbg_sel = 5'd10; #1; check("dbg_r10", o_dbg_data, 32'hAA);
    i_dbg_sel = 5'd31; #1; check("dbg_r31", o_dbg_data, 32'h20F);
    drain();

    // ---------------- table stream with random backpressure ----------------
    k = 0;
    cyc = 0;
    while ((k < NV || sb_q.size() != 0) && cyc < 3000) begin
      i_ready       = ($urandom_range(0, 3) != 0);
      i_valid_in    = (k < NV) && ($urandom_range(0, 4) != 0);
      i_instruction = tbl[(k < NV) ? k : 0].instr;
      i_pc_next     = tbl[(k < NV) ? k : 0].pc;
      #1;
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", o_pc_next, 32'hFFFFFFFF);
        end else begin
          idx = sb_q.pop_front();
          check($sformatf("vec%0d_fields", idx), {o_opcode, o_rs, o_rt, o_rd, o_sa}, tbl[idx].fields);
          check($sformatf("vec%0d_ctrl", idx), ctrl_now(), tbl[idx].ctrl);
          check($sformatf("vec%0d_data", idx),
                {o_pc_next, o_data_rs, o_data_rt, o_extended, o_pc_jump},
                {tbl[idx].pc, tbl[idx].drs, tbl[idx].drt, tbl[idx].ext, tbl[idx].jmp});
        end
      end
      if (i_valid_in && o_ready_in) begin
        sb_q.push_back(k);
        k++;
      end
      tick();
      cyc++;
    end
    check("table_issued", k, NV);
    check("table_drained", sb_q.size(), 0);
    drain();

    // ---------------- load-use stall: LW r2 ; ADD r3,r2,r1 ----------------
    i_valid_in = 1'b1; i_instruction = 32'h8C220000; i_pc_next = 32'h600;
    tick();
    i_instruction = 32'h00411820; i_pc_next = 32'h604;
    tick();
    i_valid_in = 1'b0;
    #1;
    check("lu_lw_issued", {o_valid, o_opcode, o_mem_read}, {1'b1, 6'h23, 1'b1});
    check("lu_ready_in_low", o_ready_in, 1'b0);
    tick();
    #1;
    check("lu_bubble", {o_valid, ctrl_now()}, '0);
    check("lu_ready_in_back", o_ready_in, 1'b1);
    tick();
    check("lu_add_issued", {o_valid, o_opcode, o_rs, o_pc_next, o_reg_write}, {1'b1, 6'h00, 5'd2, 32'h604, 1'b1});
    drain();

    // ---------------- write-through bypass and r0 ----------------
    i_valid_in = 1'b1; i_instruction = 32'h20A10001; i_pc_next = 32'h400;
    tick();
    i_valid_in = 1'b0; i_wb_en = 1'b1; i_wb_sel = 5'd5; i_wb_data = 32'hDEAD;
    tick();
    check("bypass_rs5", {o_valid, o_rs, o_data_rs}, {1'b1, 5'd5, 32'hDEAD});
    i_valid_in = 1'b1; i_instruction = 32'h20010001; i_pc_next = 32'h404; i_wb_en = 1'b0;
    tick();
    i_valid_in = 1'b0; i_wb_en = 1'b1; i_wb_sel = 5'd0; i_wb_data = 32'hBEEF;
    tick();
    check("bypass_r0_reads_zero", {o_valid, o_rs, o_data_rs}, {1'b1, 5'd0, 32'h0});
    i_wb_en = 1'b0;
    i_dbg_sel = 5'd5; #1; check("dbg_r5_written", o_dbg_data, 32'hDEAD);
    drain();

    // ---------------- flush squashes IF/ID ----------------
    i_valid_in = 1'b1; i_instruction = 32'h21287FFF; i_pc_next = 32'h500;
    tick();
    i_valid_in = 1'b0; i_flush = 1'b1;
    #1;
    check("flush_ready_in", o_ready_in, 1'b0);
    tick();
    i_flush = 1'b0;
    check("flush_bubble", {o_valid, ctrl_now()}, '0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("flush_never_issued", o_valid, 1'b0);
    end
    drain();

    // ---------------- step mode ----------------
    step_instr[0] = 32'h21287FFF; step_pc[0] = 32'h100;
    step_instr[1] = 32'hACE6FFFC; step_pc[1] = 32'h104;
    step_instr[2] = 32'h10220003; step_pc[2] = 32'h108;
    i_execution_mode = 1'b1;
    i_step = 1'b0;
    ks = 0;
    prev_step = 1'b1;
    snap_v = 1'b0;
    snap_pc = '0;
    for (int c = 0; c < 12; c++) begin
      if (!prev_step) begin
        check("step_hold", {o_valid, o_pc_next}, {snap_v, snap_pc});
      end
      snap_v  = o_valid;
      snap_pc = o_pc_next;
      i_step        = ((c % 4) == 3);
      i_valid_in    = (ks < 3);
      i_instruction = step_instr[(ks < 3) ? ks : 0];
      i_pc_next     = step_pc[(ks < 3) ? ks : 0];
      #1;
      check("step_ready_in", o_ready_in, i_step);
      if (i_valid_in && o_ready_in) ks++;
      prev_step = i_step;
      tick();
    end
    check("step_final", {o_valid, o_pc_next}, {1'b1, 32'h104});
    i_step = 1'b0;
    i_execution_mode = 1'b0;
    drain();

    // ---------------- backpressure: i_ready low for 3 cycles ----------------
    i_valid_in = 1'b1; i_instruction = 32'h21287FFF; i_pc_next = 32'h200;
    tick();
    i_instruction = 32'h10220003; i_pc_next = 32'h204;
    tick();
    i_ready = 1'b0; i_instruction = 32'hACE6FFFC; i_pc_next = 32'h208;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready_in_low", o_ready_in, 1'b0);
      check("bp_hold", {o_valid, o_pc_next}, {1'b1, 32'h200});
      tick();
    end
    i_ready = 1'b1;
    #1;
    check("bp_release_hold", o_pc_next, 32'h200);
    tick();
    check("bp_next_y", {o_valid, o_pc_next}, {1'b1, 32'h204});
    i_valid_in = 1'b0;
    tick();
    check("bp_next_z", {o_valid, o_pc_next}, {1'b1, 32'h208});
    drain();

    // ---------------- HALT sticky, then reset discards in-flight ----------------
    i_ready = 1'b0;
    i_valid_in = 1'b1; i_instruction = 32'hFC000000; i_pc_next = 32'h300;
    tick();
    i_instruction = 32'h21287FFF; i_pc_next = 32'h304;
    tick();
    #1;
    check("halt_set", {o_halted, o_valid, o_opcode}, {1'b1, 1'b1, 6'h3F});
    check("halt_ready_in", o_ready_in, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      check("halt_sticky", {o_halted, o_ready_in, o_pc_next}, {1'b1, 1'b0, 32'h300});
    end
    i_ready = 1'b1;
    tick();
    check("halt_frozen", {o_halted, o_opcode, o_pc_next}, {1'b1, 6'h3F, 32'h300});
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_valid_in = 1'b0;
    #1;
    check("halt_cleared", {o_halted, o_valid}, 2'b00);
    repeat (2) tick();
    check("reset_discards_inflight", o_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
